// File: rtl/contador_pkg.sv
// Shared types, 7-segment codes and digit helpers for the BCD counter/display block.
package contador_pkg;
  typedef logic [3:0] bcd_digit_t;

  // gfedcba, active-high
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic bcd_digit_t clamp_bcd(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD digit to gfedcba decoder with a blanking input.
module bcd_a_7seg
  import contador_pkg::*;
(
  input  bcd_digit_t  digit_i,
  input  logic        blank_i,
  output logic [6:0]  seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_OFF;
      endcase
    end
  end
endmodule

// File: rtl/contador_display_mux.sv
// N-digit BCD up/down counter with prescaled tick and a registered,
// multiplexed 7-segment scan driver.
module contador_display_mux
  import contador_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int COUNT_DIV      = 1000000,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);
  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  logic [CW-1:0]             presc_q;
  logic [SW-1:0]             scan_q;
  logic [IW-1:0]             idx_q;
  bcd_digit_t [DIGITS-1:0]   cnt_q, cnt_d, inc, dec;
  logic                      wrap_q, wrap_d, carry, borrow, tick, scan_end;
  logic [DIGITS-1:0]         lz;
  logic [6:0]                seg7;
  logic                      blank;
  logic [7:0]                seg_q;
  logic [DIGITS-1:0]         sel_q;

  assign tick     = (presc_q == CW'(COUNT_DIV - 1));
  assign scan_end = (scan_q == SW'(SCAN_DIV - 1));

  // Ripple increment/decrement; carry/borrow out of the top digit is the wrap.
  always_comb begin
    carry  = 1'b1;
    borrow = 1'b1;
    inc    = cnt_q;
    dec    = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[i] >= 4'd9) inc[i] = 4'd0;
        else begin inc[i] = cnt_q[i] + 4'd1; carry = 1'b0; end
      end
      if (borrow) begin
        if (cnt_q[i] == 4'd0) dec[i] = 4'd9;
        else begin dec[i] = cnt_q[i] - 4'd1; borrow = 1'b0; end
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) cnt_d = '0;
    else if (load) begin
      for (int i = 0; i < DIGITS; i++) cnt_d[i] = clamp_bcd(load_val[4*i +: 4]);
    end else if (tick && en) begin
      cnt_d  = up_dn ? inc : dec;
      wrap_d = up_dn ? carry : borrow;
    end
  end

  // lz[i]: digits i..DIGITS-1 are all zero
  always_comb begin
    logic allz;
    allz = 1'b1;
    lz   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz  = allz && (cnt_q[i] == 4'd0);
      lz[i] = allz;
    end
  end

  assign blank = blank_lz && (idx_q != '0) && lz[idx_q];

  bcd_a_7seg u_dec (
    .digit_i (cnt_q[idx_q]),
    .blank_i (blank),
    .seg_o   (seg7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= {8{SEG_INV}};
      sel_q   <= {DIGITS{SEL_INV}};
    end else begin
      presc_q <= tick ? '0 : presc_q + CW'(1);
      scan_q  <= scan_end ? '0 : scan_q + SW'(1);
      if (scan_end) idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      seg_q   <= {1'b0, seg7} ^ {8{SEG_INV}};
      sel_q   <= (DIGITS'(1) << idx_q) ^ {DIGITS{SEL_INV}};
    end
  end

  assign count_bcd = cnt_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign sel       = sel_q;
endmodule

// File: tb/tb_contador_display_mux.sv
// Directed bench: active-high and active-low instances share one stimulus stream.
module tb_contador_display_mux;
  logic        clk = 1'b0;
  logic        rst, en, up_dn, clear, load, blank_lz;
  logic [15:0] load_val;
  logic [7:0]  seg_h, seg_l;
  logic [3:0]  sel_h, sel_l;
  logic [15:0] cnt_h, cnt_l;
  logic        wrap_h, wrap_l;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  contador_display_mux #(.DIGITS(4), .COUNT_DIV(2), .SCAN_DIV(4),
                         .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_ah (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .seg(seg_h), .sel(sel_h),
    .count_bcd(cnt_h), .wrap(wrap_h));

  contador_display_mux #(.DIGITS(4), .COUNT_DIV(2), .SCAN_DIV(4),
                         .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .seg(seg_l), .sel(sel_l),
    .count_bcd(cnt_l), .wrap(wrap_l));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves rst low; the next edge is the first post-reset edge, prescaler at 0.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = 16'h0; blank_lz = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = 16'h0; blank_lz = 1'b1;
    repeat (3) step();
    tests++; if (cnt_h !== 16'h0000) begin fails++; $display("FAIL reset_count got %h exp 0000", cnt_h); end
    tests++; if (wrap_h !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b exp 0", wrap_h); end
    tests++; if (seg_h !== 8'h00 || sel_h !== 4'b0000) begin fails++; $display("FAIL reset_out_ah got seg %h sel %b exp 00 0000", seg_h, sel_h); end
    tests++; if (seg_l !== 8'hFF || sel_l !== 4'b1111) begin fails++; $display("FAIL reset_out_al got seg %h sel %b exp FF 1111", seg_l, sel_l); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [15:0] exp_cnt [10];
    exp_cnt = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    step();
    tests++; if (cnt_h !== 16'h0000) begin fails++; $display("FAIL count_no_tick got %h exp 0000", cnt_h); end
    for (int k = 0; k < 10; k++) begin
      step();
      tests++; if (cnt_h !== exp_cnt[k]) begin fails++; $display("FAIL count_up[%0d] got %h exp %h", k, cnt_h, exp_cnt[k]); end
      if (k < 9) step();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    load = 1'b1; load_val = 16'h9998;
    step();                                   // edge1: load, prescaler -> 1
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();                                   // edge2: tick
    tests++; if (cnt_h !== 16'h9999 || wrap_h !== 1'b0) begin fails++; $display("FAIL wrap_pre got %h/%b exp 9999/0", cnt_h, wrap_h); end
    step();
    tests++; if (wrap_h !== 1'b0) begin fails++; $display("FAIL wrap_idle got %b exp 0", wrap_h); end
    step();                                   // edge4: tick, wraps
    tests++; if (cnt_h !== 16'h0000 || wrap_h !== 1'b1) begin fails++; $display("FAIL wrap_up got %h/%b exp 0000/1", cnt_h, wrap_h); end
    up_dn = 1'b0;
    step();
    tests++; if (cnt_h !== 16'h0000 || wrap_h !== 1'b0) begin fails++; $display("FAIL wrap_pulse_len got %h/%b exp 0000/0", cnt_h, wrap_h); end
    step();                                   // edge6: tick, borrow out
    tests++; if (cnt_h !== 16'h9999 || wrap_h !== 1'b1) begin fails++; $display("FAIL wrap_dn got %h/%b exp 9999/1", cnt_h, wrap_h); end
    step();
    tests++; if (wrap_h !== 1'b0) begin fails++; $display("FAIL wrap_dn_len got %b exp 0", wrap_h); end
    step();                                   // edge8: tick, 9999 -> 9998
    tests++; if (cnt_h !== 16'h9998 || wrap_h !== 1'b0) begin fails++; $display("FAIL dn_step got %h/%b exp 9998/0", cnt_h, wrap_h); end
  endtask

  task automatic test_load_clear();
    do_reset();
    load = 1'b1; load_val = 16'hF3A7;
    step();
    tests++; if (cnt_h !== 16'h9397) begin fails++; $display("FAIL load_clamp got %h exp 9397", cnt_h); end
    clear = 1'b1;
    step();
    tests++; if (cnt_h !== 16'h0000 || wrap_h !== 1'b0) begin fails++; $display("FAIL clear_over_load got %h/%b exp 0000/0", cnt_h, wrap_h); end
    // load coinciding with a tick: load wins, tick lost
    clear = 1'b0; en = 1'b1; up_dn = 1'b1; load_val = 16'h0005;
    step();                                   // edge3: no tick
    step();                                   // edge4: tick and load together
    tests++; if (cnt_h !== 16'h0005 || wrap_h !== 1'b0) begin fails++; $display("FAIL load_over_tick got %h/%b exp 0005/0", cnt_h, wrap_h); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_scan();
    do_reset();
    load = 1'b1; load_val = 16'h0042;
    step();                                   // out edge1: idx0 of old count
    load = 1'b0; blank_lz = 1'b1;
    for (int k = 2; k <= 29; k++) begin
      if (k == 18) blank_lz = 1'b0;
      step();
      case (k)
        2, 4: begin tests++; if (sel_h !== 4'b0001 || seg_h !== 8'h5B) begin fails++; $display("FAIL scan_d0 k=%0d got %b/%h exp 0001/5B", k, sel_h, seg_h); end end
        5, 8: begin tests++; if (sel_h !== 4'b0010 || seg_h !== 8'h66) begin fails++; $display("FAIL scan_d1 k=%0d got %b/%h exp 0010/66", k, sel_h, seg_h); end end
        9:    begin tests++; if (sel_h !== 4'b0100 || seg_h !== 8'h00) begin fails++; $display("FAIL scan_d2_blank got %b/%h exp 0100/00", sel_h, seg_h); end end
        13:   begin tests++; if (sel_h !== 4'b1000 || seg_h !== 8'h00) begin fails++; $display("FAIL scan_d3_blank got %b/%h exp 1000/00", sel_h, seg_h); end end
        17:   begin tests++; if (sel_h !== 4'b0001 || seg_h !== 8'h5B) begin fails++; $display("FAIL scan_wrap got %b/%h exp 0001/5B", sel_h, seg_h); end end
        25:   begin tests++; if (sel_h !== 4'b0100 || seg_h !== 8'h3F) begin fails++; $display("FAIL scan_d2_noblank got %b/%h exp 0100/3F", sel_h, seg_h); end end
        29:   begin tests++; if (sel_h !== 4'b1000 || seg_h !== 8'h3F) begin fails++; $display("FAIL scan_d3_noblank got %b/%h exp 1000/3F", sel_h, seg_h); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_polarity();
    do_reset();
    load = 1'b1; load_val = 16'h0008;
    step();
    load = 1'b0;
    step();                                   // idx0 showing 8
    tests++; if (seg_l !== 8'h80 || sel_l !== 4'b1110) begin fails++; $display("FAIL pol_low got %h/%b exp 80/1110", seg_l, sel_l); end
    tests++; if (seg_h !== 8'h7F || sel_h !== 4'b0001) begin fails++; $display("FAIL pol_high got %h/%b exp 7F/0001", seg_h, sel_h); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load = 1'b1; load_val = 16'h0123;
    step();
    load = 1'b0; en = 1'b1;
    tests++; if (cnt_h !== 16'h0123) begin fails++; $display("FAIL midrst_pre got %h exp 0123", cnt_h); end
    rst = 1'b1;
    step();
    tests++; if (cnt_h !== 16'h0000 || sel_h !== 4'b0000 || seg_h !== 8'h00) begin fails++; $display("FAIL midrst got %h/%b/%h exp 0000/0000/00", cnt_h, sel_h, seg_h); end
    rst = 1'b0; en = 1'b0;
    step();
    tests++; if (sel_h !== 4'b0001 || seg_h !== 8'h3F) begin fails++; $display("FAIL midrst_first got %b/%h exp 0001/3F", sel_h, seg_h); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_load_clear();
    test_scan();
    test_polarity();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
